// File: rtl/demux4_stream.sv
// demux4_stream: one-to-four valid/ready steering with a one-entry holding register per lane.
// Define DEMUX4_CNT_EN to add saturating per-lane delivery counters with a synchronous clear.
module demux4_stream #(
  parameter int width = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [width-1:0] out_data0,
  output logic [width-1:0] out_data1,
  output logic [width-1:0] out_data2,
  output logic [width-1:0] out_data3
`ifdef DEMUX4_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);
  logic [3:0]       valid_q;
  logic [width-1:0] data_q [4];
  logic [3:0]       load;
  logic [3:0]       pop;
  assign in_ready  = ~valid_q[in_sel] | out_ready[in_sel];
  assign load      = (in_valid & in_ready) ? 4'b0001 << in_sel : 4'b0000;
  assign pop       = valid_q & out_ready;
  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  // a load on a popping lane keeps it valid, sustaining one word per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      valid_q <= load | (valid_q & ~pop);
      for (int i = 0; i < 4; i++) if (load[i]) data_q[i] <= in_data;
    end
  end
`ifdef DEMUX4_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        cnt_q[i] <= cnt_clr ? '0 : (pop[i] && !(&cnt_q[i])) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end
  end
  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed and randomized checks of demux4_stream against per-lane FIFO queues.
module tb_demux4_stream;
  localparam int W  = 16;
  localparam int CW = 4;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = '0;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX4_CNT_EN
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
`endif
  int checks = 0;
  int errors = 0;
  logic [W-1:0] lq [4][$];
  logic [W-1:0] last [4];
  logic         prev_stall = 1'b0;
  logic [1:0]   prev_sel;
  logic [W-1:0] prev_data;

  always #5 clk = ~clk;

  demux4_stream #(
    .width(W)
`ifdef DEMUX4_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3)
`ifdef DEMUX4_CNT_EN
    , .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
  );

  function automatic logic [W-1:0] dout(int i);
    return i == 0 ? out_data0 : i == 1 ? out_data1 : i == 2 ? out_data2 : out_data3;
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v = '0;
    for (int i = 0; i < 4; i++) v[i] = lq[i].size() != 0;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      lq[i].delete();
      last[i] = '0;
    end
    prev_stall = 1'b0;
  endtask

  // advances the reference queues by one edge, then the clock; also polices the source hold rule
  task automatic tick();
    logic acc;
    if (prev_stall) begin
      checks++;
      if (!in_valid || in_sel !== prev_sel || in_data !== prev_data) begin
        errors++;
        $display("FAIL hold: valid %b sel %0d data %h, required held sel %0d data %h", in_valid, in_sel, in_data, prev_sel, prev_data);
      end
    end
    acc = in_valid && (lq[in_sel].size() == 0 || out_ready[in_sel]);
    for (int i = 0; i < 4; i++)
      if (out_ready[i] && lq[i].size() != 0) void'(lq[i].pop_front());
    if (acc) begin
      lq[in_sel].push_back(in_data);
      last[in_sel] = in_data;
    end
    prev_stall = in_valid && !acc;
    prev_sel   = in_sel;
    prev_data  = in_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    out_ready = 4'b0000;
    in_valid  = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b, required 0000", out_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout(i) !== '0) begin errors++; $display("FAIL reset_data%0d: got %h, required 0000", i, dout(i)); end
      in_sel = 2'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready sel%0d: got %b, required 1", i, in_ready); end
    end
    tick();
  endtask

  task automatic test_two_lanes();
    out_ready = 4'b1111;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 16'hA001;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL two_ready: got %b, required 1", in_ready); end
    tick();
    in_sel = 2'd2; in_data = 16'hB002;
    checks++;
    if (out_valid !== 4'b0001) begin errors++; $display("FAIL two_valid0: got %b, required 0001", out_valid); end
    checks++;
    if (out_data0 !== 16'hA001) begin errors++; $display("FAIL two_data0: got %h, required a001", out_data0); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100) begin errors++; $display("FAIL two_valid2: got %b, required 0100", out_valid); end
    checks++;
    if (out_data2 !== 16'hB002) begin errors++; $display("FAIL two_data2: got %h, required b002", out_data2); end
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL two_drain: got %b, required 0000", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 4'b1101;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h1111;
    tick();
    in_sel = 2'd3; in_data = 16'h3333;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready3: got %b, required 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 4'b1010) begin errors++; $display("FAIL stall_valid: got %b, required 1010", out_valid); end
    checks++;
    if (out_data3 !== 16'h3333) begin errors++; $display("FAIL stall_data3: got %h, required 3333", out_data3); end
    in_sel = 2'd1; in_data = 16'h2222;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_blocked: got %b, required 0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 4'b0010 || out_data1 !== 16'h1111) begin
      errors++; $display("FAIL stall_hold: got %b/%h, required 0010/1111", out_valid, out_data1);
    end
    out_ready = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b, required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0010 || out_data1 !== 16'h2222) begin
      errors++; $display("FAIL stall_second: got %b/%h, required 0010/2222", out_valid, out_data1);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL stall_drain: got %b, required 0000", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_sel = 2'd2; in_data = 16'(k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready %0d: got %b, required 1", k, in_ready); end
      tick();
      checks++;
      if (out_valid !== 4'b0100 || out_data2 !== 16'(k)) begin
        errors++; $display("FAIL stream_word %0d: got %b/%h, required 0100/%h", k, out_valid, out_data2, 16'(k));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL stream_drain: got %b, required 0000", out_valid); end
  endtask

  task automatic test_random();
    logic er;
    for (int n = 0; n < 400; n++) begin
      if (!prev_stall) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_sel   = 2'($urandom);
        in_data  = W'($urandom);
      end
      out_ready = 4'($urandom);
      #1;
      er = lq[in_sel].size() == 0 || out_ready[in_sel];
      checks++;
      if (in_ready !== er) begin errors++; $display("FAIL rand_ready %0d: got %b, required %b", n, in_ready, er); end
      tick();
      checks++;
      if (out_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid %0d: got %b, required %b", n, out_valid, exp_valid()); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dout(i) !== last[i]) begin errors++; $display("FAIL rand_data%0d %0d: got %h, required %h", i, n, dout(i), last[i]); end
      end
    end
    in_valid = 1'b0;
    out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 16'h0DEF;
    tick();
    in_sel = 2'd3; in_data = 16'h3ABC;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b1001) begin errors++; $display("FAIL areset_loaded: got %b, required 1001", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL areset_valid: got %b, required 0000", out_valid); end
    checks++;
    if (out_data0 !== '0 || out_data3 !== '0) begin
      errors++; $display("FAIL areset_data: got %h/%h, required 0000/0000", out_data0, out_data3);
    end
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 4'b0000) begin errors++; $display("FAIL areset_nodeliver %0d: got %b, required 0000", k, out_valid); end
    end
  endtask

`ifdef DEMUX4_CNT_EN
  task automatic test_counters();
    out_ready = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_sel = 2'd0; in_data = 16'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (cnt0 !== 4'hF) begin errors++; $display("FAIL cnt_sat: got %h, required f", cnt0); end
    checks++;
    if (cnt1 !== 4'h0) begin errors++; $display("FAIL cnt_other: got %h, required 0", cnt1); end
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 16'h5555;
    tick();
    in_valid = 1'b0;
    out_ready = 4'b0001;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (cnt0 !== 4'h0 || out_valid[0] !== 1'b0) begin
      errors++; $display("FAIL cnt_clr: got %h valid %b, required 0 valid 0", cnt0, out_valid[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_lanes();
    test_stall();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef DEMUX4_CNT_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
